// File: rtl/fir_tap_loader.sv
// Coefficient store plus a streaming loader that feeds an N-tap FIR over a valid/ready link.
// Optional FIR_TAP_LOADER_CHECKSUM_EN adds tap_checksum, the signed sum of the taps sent in the last load.
module fir_tap_loader #(
  parameter int G_TAP_WIDTH     = 16,
  parameter int G_NUM_TAPS_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [G_NUM_TAPS_LOG2-1:0]   wr_addr,
  input  logic [G_TAP_WIDTH-1:0]       wr_data,
  input  logic                         wr_en,
  output logic                         wr_ready,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [G_TAP_WIDTH-1:0]       tap_dout,
  output logic                         tap_dout_valid,
  input  logic                         tap_dout_ready,
  input  logic                         tap_dout_done,
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
  output logic [G_TAP_WIDTH+G_NUM_TAPS_LOG2-1:0] tap_checksum,
`endif
  output logic [G_NUM_TAPS_LOG2:0]     tap_count
);

  localparam int N = 1 << G_NUM_TAPS_LOG2;
  localparam logic [G_NUM_TAPS_LOG2-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t                       state, state_d;
  logic [G_NUM_TAPS_LOG2-1:0]   idx, idx_d;
  logic [G_NUM_TAPS_LOG2:0]     cnt, cnt_d;
  logic [G_TAP_WIDTH-1:0]       mem [N];
  logic                         xfer;
  logic                         start_acc;

  assign xfer      = tap_dout_valid & tap_dout_ready;
  assign start_acc = enable & start & ((state == S_IDLE) | (state == S_DONE));
  assign tap_dout  = mem[idx];
  assign tap_count = cnt;

  // Array is deliberately left out of reset so taps survive reset and enable=0.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ready)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_STREAM;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_STREAM: begin
        if (tap_dout_ready) begin
          idx_d = idx + 1'b1;
          cnt_d = cnt + 1'b1;
          if (idx == IDX_LAST)
            state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tap_dout_done)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    wr_ready       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    tap_dout_valid = 1'b0;
    case (state)
      S_IDLE:      wr_ready = 1'b1;
      S_STREAM: begin
        busy           = 1'b1;
        tap_dout_valid = 1'b1;
      end
      S_WAIT_DONE: busy = 1'b1;
      S_DONE: begin
        wr_ready = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FIR_TAP_LOADER_CHECKSUM_EN
  localparam int CW = G_TAP_WIDTH + G_NUM_TAPS_LOG2;
  logic [CW-1:0] csum;

  always_ff @(posedge clk) begin
    if (reset || !enable || start_acc)
      csum <= '0;
    else if (xfer)
      csum <= csum + {{G_NUM_TAPS_LOG2{tap_dout[G_TAP_WIDTH-1]}}, tap_dout};
  end

  assign tap_checksum = csum;
`else
  logic unused_start_acc;
  logic unused_xfer;
  assign unused_start_acc = start_acc;
  assign unused_xfer      = xfer;
`endif

endmodule
